// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals shared by the two-port ALU arbiter.
// The arbiter uses the slave modport; requesters, the ALU and the consumer use the master modport.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [CTL_W-1:0] req0_ctl;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [CTL_W-1:0] req1_ctl;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [CTL_W-1:0] alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;

    modport slave (
        input  req0_valid, req0_ctl, req0_a, req0_b,
        input  req1_valid, req1_ctl, req1_a, req1_b,
        input  alu_out, alu_zero, rsp_ready,
        output req0_ready, req1_ready,
        output alu_ctl, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_data, rsp_zero
    );

    modport master (
        output req0_valid, req0_ctl, req0_a, req0_b,
        output req1_valid, req1_ctl, req1_a, req1_b,
        output alu_out, alu_zero, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_ctl, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Each operation runs IDLE -> EXEC -> RESP and returns a tagged, held response.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             grant;
    logic             grant_vld;
    logic [CTL_W-1:0] sel_ctl;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant     = ~last_grant;
            grant_vld = 1'b1;
        end else if (bus.req0_valid) begin
            grant     = 1'b0;
            grant_vld = 1'b1;
        end else if (bus.req1_valid) begin
            grant     = 1'b1;
            grant_vld = 1'b1;
        end
    end

    always_comb begin
        sel_ctl = grant ? bus.req1_ctl : bus.req0_ctl;
        sel_a   = grant ? bus.req1_a   : bus.req0_a;
        sel_b   = grant ? bus.req1_b   : bus.req0_b;
    end

    // Ready only follows a valid, so in IDLE ready alone marks the accepting port.
    assign bus.req0_ready = (state == IDLE) && grant_vld && !grant;
    assign bus.req1_ready = (state == IDLE) && grant_vld &&  grant;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            bus.alu_ctl   <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        bus.alu_ctl <= sel_ctl;
                        bus.alu_a   <= sel_a;
                        bus.alu_b   <= sel_b;
                        last_grant  <= grant;
                        bus.rsp_id  <= grant;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    bus.rsp_data  <= bus.alu_out;
                    bus.rsp_zero  <= bus.alu_zero;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected responses on acceptance,
// a negedge monitor pops and compares on each response handshake.
module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int CTL_W = 4;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] data;
        logic             zero;
    } exp_t;

    logic clk;
    logic rst;
    int   check_cnt;
    int   pass_cnt;
    exp_t exp_q[$];
    int   grant_log[$];

    logic             hold_prev;
    logic             hold_id;
    logic [WIDTH-1:0] hold_data;
    logic             hold_zero;

    alu_arbiter_if #(.WIDTH(WIDTH), .CTL_W(CTL_W)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .CTL_W(CTL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: and, or, add, sub, unsigned slt; any other code yields 0.
    always_comb begin
        case (bus.alu_ctl)
            4'b0000: bus.alu_out = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_out = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_out = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_out = bus.alu_a - bus.alu_b;
            4'b0111: bus.alu_out = {31'd0, bus.alu_a < bus.alu_b};
            default: bus.alu_out = '0;
        endcase
        bus.alu_zero = (bus.alu_out == '0);
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        check_cnt++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request, wait for ready, log the grant and queue the hand-computed result.
    task automatic drive(input int p, input logic [CTL_W-1:0] c, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] ed, input logic ez);
        logic rdy;
        exp_t e;
        if (p == 0) begin
            bus.req0_ctl = c; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_ctl = c; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rdy = (p == 0) ? bus.req0_ready : bus.req1_ready;
            if (rdy) begin
                e.id = (p != 0); e.data = ed; e.zero = ez;
                exp_q.push_back(e);
                grant_log.push_back(p);
                @(posedge clk);
                #1;
                if (p == 0) bus.req0_valid = 1'b0;
                else        bus.req1_valid = 1'b0;
                return;
            end
        end
        fail_now($sformatf("req%0d_accept", p));
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic check_grants(input string name, input int exp_g[]);
        check({name, "_count"}, grant_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
            check($sformatf("%s_%0d", name, i), grant_log[i], exp_g[i]);
        grant_log.delete();
    endtask

    // Monitor: response scoreboard, hold stability under backpressure, ready legality.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_exclusive", bus.req0_ready & bus.req1_ready, 0);
            check("ready0_has_valid", bus.req0_ready & ~bus.req0_valid, 0);
            check("ready1_has_valid", bus.req1_ready & ~bus.req1_valid, 0);
            if (hold_prev) begin
                check("hold_valid", bus.rsp_valid, 1);
                check("hold_id", bus.rsp_id, hold_id);
                check("hold_data", bus.rsp_data, hold_data);
                check("hold_zero", bus.rsp_zero, hold_zero);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_response");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_id", bus.rsp_id, e.id);
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_zero", bus.rsp_zero, e.zero);
                end
            end
            hold_prev = bus.rsp_valid && !bus.rsp_ready;
            hold_id   = bus.rsp_id;
            hold_data = bus.rsp_data;
            hold_zero = bus.rsp_zero;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        int seen;
        check_cnt = 0; pass_cnt = 0; hold_prev = 1'b0;
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_ctl = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_ctl = '0; bus.req1_a = '0; bus.req1_b = '0;
        step(2);
        rst = 1'b0;

        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_id", bus.rsp_id, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        check("reset_rsp_zero", bus.rsp_zero, 0);
        check("reset_alu_ctl", bus.alu_ctl, 0);
        check("reset_alu_a", bus.alu_a, 0);
        check("reset_alu_b", bus.alu_b, 0);

        // Single request: 5 + 7, ready in the first IDLE cycle, response two cycles on.
        bus.req0_ctl = 4'b0010; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_valid = 1'b1;
        #1;
        check("first_req0_ready", bus.req0_ready, 1);
        drive(0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0);
        check("exec_rsp_valid", bus.rsp_valid, 0);
        check("exec_alu_ctl", bus.alu_ctl, 4'b0010);
        step(1);
        check("latency_rsp_valid", bus.rsp_valid, 1);
        check("latency_rsp_id", bus.rsp_id, 0);
        step(2);
        check("idle_keeps_alu_a", bus.alu_a, 32'd5);
        grant_log.delete();

        // Both valid from reset: port 0 sub 9-9 first, then port 1 or 0xF0|0x0F.
        do_reset();
        fork
            drive(0, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1);
            drive(1, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        join
        check_grants("pair_grant", '{0, 1});

        // Continuous contention over six operations.
        fork
            begin
                drive(0, 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0);
                drive(0, 4'b0110, 32'd10, 32'd4, 32'd6, 1'b0);
                drive(0, 4'b0000, 32'hC, 32'hA, 32'h8, 1'b0);
            end
            begin
                drive(1, 4'b0001, 32'd1, 32'd2, 32'd3, 1'b0);
                drive(1, 4'b0111, 32'd5, 32'd3, 32'd0, 1'b1);
                drive(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
            end
        join
        check_grants("rr_grant", '{0, 1, 0, 1, 0, 1});

        // Backpressure for 5 cycles with port 1 waiting behind port 0.
        step(3);
        bus.rsp_ready = 1'b0;
        fork
            drive(0, 4'b0010, 32'd100, 32'd23, 32'd123, 1'b0);
            drive(1, 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
            begin
                seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    if (bus.rsp_valid) seen = 1;
                end
                if (!seen) fail_now("bp_rsp_valid");
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_req1_ready", bus.req1_ready, 0);
                end
                #6;
                bus.rsp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("bp_req1_ready_after", bus.req1_ready, 1);
            end
        join
        check_grants("bp_grant", '{0, 1});
        step(3);

        // Reset while the 3-8 subtraction is in EXEC: it is dropped, then re-run.
        drive(0, 4'b0110, 32'd3, 32'd8, 32'hFFFF_FFFB, 1'b0);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("rst_mid_rsp_valid", bus.rsp_valid, 0);
        check("rst_mid_alu_ctl", bus.alu_ctl, 0);
        check("rst_mid_alu_a", bus.alu_a, 0);
        check("rst_mid_alu_b", bus.alu_b, 0);
        check("rst_mid_rsp_data", bus.rsp_data, 0);
        step(2);
        check("rst_hold_rsp_valid", bus.rsp_valid, 0);
        rst = 1'b0;
        step(2);
        check("post_rst_no_rsp", bus.rsp_valid, 0);
        drive(0, 4'b0110, 32'd3, 32'd8, 32'hFFFF_FFFB, 1'b0);
        step(3);

        // Undefined control code.
        drive(1, 4'b1010, 32'hFFFF, 32'd1, 32'd0, 1'b1);
        check("undef_alu_ctl_passthru", bus.alu_ctl, 4'b1010);

        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (exp_q.size() == 0) seen = 1;
        end
        if (!seen) fail_now("drain_scoreboard");
        step(2);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
